// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: recovers pixel coordinates and display-enable from incoming VGA
// sync/rgb, checks the timing against the nominal mode and reports lock, errors and frame starts.
module vga_sync_decoder #(
    parameter int H_VIS       = 800,
    parameter int H_FP        = 56,
    parameter int H_SYNC      = 120,
    parameter int H_TOTAL     = 1040,
    parameter int V_VIS       = 600,
    parameter int V_FP        = 37,
    parameter int V_SYNC      = 6,
    parameter int V_TOTAL     = 666,
    parameter bit SYNC_POL    = 1'b1,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [7:0]  rgb_in,
    output logic [10:0] x,
    output logic [10:0] y,
    output logic        de,
    output logic [7:0]  rgb_out,
    output logic        frame_start,
    output logic        locked,
    output logic        sync_err,
    output logic [15:0] err_count
);
    typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

    localparam int TW = $clog2(2 * H_TOTAL);
    localparam int GW = $clog2(LOCK_FRAMES + 1);
    localparam logic [10:0] H_RLD  = 11'(H_VIS + H_FP);
    localparam logic [10:0] V_RLD  = 11'(V_VIS + V_FP);
    localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS_W = 11'(H_VIS);
    localparam logic [10:0] V_VIS_W = 11'(V_VIS);
    localparam logic [TW-1:0] TMR_MAX = TW'(2 * H_TOTAL - 1);
    localparam logic [GW-1:0] GOOD_LOCK = GW'(LOCK_FRAMES);

    if (H_VIS + H_FP + H_SYNC > H_TOTAL || V_VIS + V_FP + V_SYNC > V_TOTAL) begin : g_bad_timing
        $error("sync pulse does not fit inside the line or frame");
    end

    state_t          state, state_d;
    logic [GW-1:0]   good, good_d;
    logic [TW-1:0]   tmr;
    logic            hs_s1, vs_s1, hs_p, vs_p;
    logic [7:0]      rgb_s1;
    logic [10:0]     hp_n, vp_n, hp_d, vp_d;
    logic            h_edge, v_edge, h_wrap, tout, miss, count_err, lock_d, de_d;

    // x/y are the position counters themselves; hp_n/vp_n are the free-running prediction
    always_comb begin
        h_edge    = hs_s1 & ~hs_p;
        v_edge    = vs_s1 & ~vs_p;
        h_wrap    = x == H_LAST;
        hp_n      = h_wrap ? '0 : x + 11'd1;
        vp_n      = !h_wrap ? y : (y == V_LAST ? '0 : y + 11'd1);
        tout      = !h_edge && tmr == TMR_MAX;
        miss      = (h_edge && hp_n != H_RLD) || (v_edge && vp_n != V_RLD) || tout;
        hp_d      = h_edge ? H_RLD : hp_n;
        vp_d      = v_edge ? V_RLD : vp_n;
        count_err = miss && state != SEARCH;
        state_d   = state;
        good_d    = good;
        case (state)
            SEARCH: if (v_edge) begin
                state_d = TRACK;
                good_d  = '0;
            end
            TRACK: if (miss) state_d = SEARCH;
            else if (v_edge) begin
                good_d  = good + 1'b1;
                state_d = (good_d >= GOOD_LOCK) ? LOCKED : TRACK;
            end
            LOCKED: if (miss) state_d = SEARCH;
            default: state_d = SEARCH;
        endcase
        lock_d = state_d == LOCKED;
        de_d   = lock_d && hp_d < H_VIS_W && vp_d < V_VIS_W;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= SEARCH;
            good        <= '0;
            tmr         <= '0;
            hs_s1       <= 1'b0;
            vs_s1       <= 1'b0;
            hs_p        <= 1'b0;
            vs_p        <= 1'b0;
            rgb_s1      <= '0;
            x           <= '0;
            y           <= '0;
            de          <= 1'b0;
            rgb_out     <= '0;
            frame_start <= 1'b0;
            locked      <= 1'b0;
            sync_err    <= 1'b0;
            err_count   <= '0;
        end else begin
            hs_s1       <= hsync_in ^ ~SYNC_POL;
            vs_s1       <= vsync_in ^ ~SYNC_POL;
            hs_p        <= hs_s1;
            vs_p        <= vs_s1;
            rgb_s1      <= rgb_in;
            state       <= state_d;
            good        <= good_d;
            tmr         <= (h_edge || tout) ? '0 : tmr + 1'b1;
            x           <= hp_d;
            y           <= vp_d;
            locked      <= lock_d;
            de          <= de_d;
            rgb_out     <= de_d ? rgb_s1 : '0;
            frame_start <= lock_d && hp_d == '0 && vp_d == '0;
            sync_err    <= count_err;
            if (count_err && err_count != '1) err_count <= err_count + 1'b1;
        end
    end
endmodule
